// File: rtl/barcode_entry_controller_pkg.sv
// Shared types and sizes for the barcode entry controller and its one-hot encoder.
package barcode_entry_controller_pkg;

  localparam int NUM_PRODUCTS = 12;
  localparam int DIGIT_W      = 4;
  localparam int BARCODE_W    = 16;
  localparam int NUM_DIGITS   = 4;
  localparam int COUNT_W      = 3;
  localparam int INDEX_W      = 4;

  typedef enum logic [1:0] {
    ENTRY  = 2'd0,
    REVIEW = 2'd1,
    ISSUE  = 2'd2
  } state_e;

  function automatic logic digit_legal(input logic [2:0] d);
    return (d >= 3'd1) && (d <= 3'd4);
  endfunction

endpackage

// File: rtl/barcode_entry_controller_onehot12_encoder.sv
// Converts the 12-bit product match vector into a product index plus a flag that
// says the vector was exactly one-hot.
module onehot12_encoder
  import barcode_entry_controller_pkg::*;
(
  input  logic [NUM_PRODUCTS-1:0] onehot_i,
  output logic [INDEX_W-1:0]      index_o,
  output logic                    valid_o
);

  always_comb begin
    index_o = '0;
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      if (onehot_i[i]) index_o = INDEX_W'(i);
    end
  end

  // Non-zero with no second bit set.
  assign valid_o = (onehot_i != '0) &&
                   ((onehot_i & (onehot_i - NUM_PRODUCTS'(1))) == '0);

endmodule

// File: rtl/barcode_entry_controller.sv
// Keypad barcode entry FSM (ENTRY -> REVIEW -> ISSUE) with product lookup and cart handshake.
// Optional inactivity clear is built only when BARCODE_TIMEOUT_EN is defined.
module barcode_entry_controller
  import barcode_entry_controller_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd250_000_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [2:0]              Digit_in,
  input  logic                    Digit_valid,
  input  logic                    Backspace,
  input  logic                    Clear,
  input  logic                    Confirm,
  input  logic [NUM_PRODUCTS-1:0] Match_in,
  input  logic                    Item_ready,
  output logic [BARCODE_W-1:0]    Barcode_out,
  output logic [COUNT_W-1:0]      NumOfBarcodeDigitsEntered,
  output logic                    BarcodeCompleted,
  output logic                    Item_valid,
  output logic [INDEX_W-1:0]      Item_index,
  output logic                    Error
);

  state_e               state_q, state_d;
  logic [BARCODE_W-1:0] barcode_q, barcode_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic [INDEX_W-1:0]   index_q, index_d;
  logic                 error_q, error_d;
  logic                 completed_q;
  logic                 valid_q;
  logic                 accept;
  logic [4:0]           wr_lsb, clr_lsb;
  logic [INDEX_W-1:0]   enc_index;
  logic                 enc_valid;

  onehot12_encoder u_encoder (
    .onehot_i (Match_in),
    .index_o  (enc_index),
    .valid_o  (enc_valid)
  );

`ifdef BARCODE_TIMEOUT_EN
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic        tmo_hit;

  assign tmo_hit = (state_q != ISSUE) && (count_q != '0) &&
                   (tmo_cnt_q == (TIMEOUT_CYCLES - 32'd1));

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (accept || tmo_hit) begin
      tmo_cnt_d = '0;
    end else if ((state_q != ISSUE) && (count_q != '0)) begin
      tmo_cnt_d = tmo_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_cnt_q <= '0;
    else        tmo_cnt_q <= tmo_cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^{TIMEOUT_CYCLES, accept};
`endif

  // Digit k (0-based) lives in nibble 3-k, so the next write and the last
  // written nibble both follow directly from the current count.
  assign wr_lsb  = 5'd12 - {count_q, 2'b00};
  assign clr_lsb = 5'd16 - {count_q, 2'b00};

  always_comb begin
    state_d   = state_q;
    barcode_d = barcode_q;
    count_d   = count_q;
    index_d   = index_q;
    error_d   = 1'b0;
    accept    = 1'b0;

    if (state_q == ISSUE) begin
      if (Item_ready) begin
        state_d   = ENTRY;
        barcode_d = '0;
        count_d   = '0;
      end
    end else begin
      if (Clear) begin
        accept    = 1'b1;
        state_d   = ENTRY;
        barcode_d = '0;
        count_d   = '0;
      end else if (Backspace) begin
        if (count_q != '0) begin
          accept    = 1'b1;
          barcode_d = barcode_q & ~(16'hF << clr_lsb);
          count_d   = count_q - 3'd1;
          state_d   = ENTRY;
        end
      end else if (Digit_valid) begin
        if ((state_q == ENTRY) && digit_legal(Digit_in)) begin
          accept    = 1'b1;
          barcode_d = barcode_q | ({13'd0, Digit_in} << wr_lsb);
          count_d   = count_q + 3'd1;
          if (count_q == 3'd3) state_d = REVIEW;
        end
      end else if (Confirm) begin
        if (state_q == REVIEW) begin
          accept = 1'b1;
          if (enc_valid) begin
            state_d = ISSUE;
            index_d = enc_index;
          end else begin
            error_d   = 1'b1;
            state_d   = ENTRY;
            barcode_d = '0;
            count_d   = '0;
          end
        end
      end

`ifdef BARCODE_TIMEOUT_EN
      if (!accept && tmo_hit) begin
        state_d   = ENTRY;
        barcode_d = '0;
        count_d   = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ENTRY;
      barcode_q   <= '0;
      count_q     <= '0;
      index_q     <= '0;
      error_q     <= 1'b0;
      completed_q <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      barcode_q   <= barcode_d;
      count_q     <= count_d;
      index_q     <= index_d;
      error_q     <= error_d;
      completed_q <= (state_d == REVIEW);
      valid_q     <= (state_d == ISSUE);
    end
  end

  assign Barcode_out               = barcode_q;
  assign NumOfBarcodeDigitsEntered = count_q;
  assign BarcodeCompleted          = completed_q;
  assign Item_valid                = valid_q;
  assign Item_index                = index_q;
  assign Error                     = error_q;

endmodule

// File: tb/tb_barcode_entry_controller.sv
// Self-checking bench: directed scenarios plus randomized strobes against a
// queue-based model of the keypad entry and cart handshake.
module tb_barcode_entry_controller;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  Digit_in = '0;
  logic        Digit_valid = 1'b0;
  logic        Backspace = 1'b0;
  logic        Clear = 1'b0;
  logic        Confirm = 1'b0;
  logic [11:0] Match_in = '0;
  logic        Item_ready = 1'b0;
  logic [15:0] Barcode_out;
  logic [2:0]  NumOfBarcodeDigitsEntered;
  logic        BarcodeCompleted;
  logic        Item_valid;
  logic [3:0]  Item_index;
  logic        Error;

  int checks = 0;
  int errors = 0;

  int q[$];
  bit m_issue = 1'b0;
  int m_idx = 0;
  bit m_err = 1'b0;
  int m_idle = 0;

  barcode_entry_controller #(.TIMEOUT_CYCLES(32'(TMO))) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .Digit_in                  (Digit_in),
    .Digit_valid               (Digit_valid),
    .Backspace                 (Backspace),
    .Clear                     (Clear),
    .Confirm                   (Confirm),
    .Match_in                  (Match_in),
    .Item_ready                (Item_ready),
    .Barcode_out               (Barcode_out),
    .NumOfBarcodeDigitsEntered (NumOfBarcodeDigitsEntered),
    .BarcodeCompleted          (BarcodeCompleted),
    .Item_valid                (Item_valid),
    .Item_index                (Item_index),
    .Error                     (Error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_barcode();
    logic [15:0] v = '0;
    for (int i = 0; i < q.size(); i++) v = v | (16'(q[i]) << (12 - 4 * i));
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    m_issue = 1'b0;
    m_idx = 0;
    m_err = 1'b0;
    m_idle = 0;
  endtask

  task automatic model_step(input bit dv, input int dig, input bit bs, input bit clr,
                            input bit cf, input logic [11:0] match, input bit rdy);
    bit acc = 1'b0;
    int ones = 0;
    int pos = 0;
    m_err = 1'b0;
    if (m_issue) begin
      if (rdy) begin
        m_issue = 1'b0;
        q.delete();
      end
    end else begin
      if (clr) begin
        acc = 1'b1;
        q.delete();
      end else if (bs) begin
        if (q.size() > 0) begin
          acc = 1'b1;
          void'(q.pop_back());
        end
      end else if (dv) begin
        if (q.size() < 4 && dig >= 1 && dig <= 4) begin
          acc = 1'b1;
          q.push_back(dig);
        end
      end else if (cf) begin
        if (q.size() == 4) begin
          acc = 1'b1;
          for (int i = 0; i < 12; i++) if (match[i]) begin ones++; pos = i; end
          if (ones == 1) begin
            m_issue = 1'b1;
            m_idx = pos;
          end else begin
            m_err = 1'b1;
            q.delete();
          end
        end
      end
`ifdef BARCODE_TIMEOUT_EN
      // Idle time since the last accepted keypress; expires at TMO-1.
      if (acc) m_idle = 0;
      else if (q.size() > 0) begin
        if (m_idle == TMO - 1) begin
          q.delete();
          m_idle = 0;
        end else m_idle++;
      end
`endif
    end
  endtask

  task automatic check_all();
    check("barcode",   32'(Barcode_out), 32'(exp_barcode()));
    check("count",     32'(NumOfBarcodeDigitsEntered), 32'(q.size()));
    check("completed", 32'(BarcodeCompleted), 32'(q.size() == 4 && !m_issue));
    check("item_valid", 32'(Item_valid), 32'(m_issue));
    check("item_index", 32'(Item_index), 32'(m_idx));
    check("error",     32'(Error), 32'(m_err));
  endtask

  // Called at a falling edge: drive inputs, advance the model, sample at the next falling edge.
  task automatic cycle(input bit dv, input int dig, input bit bs, input bit clr,
                       input bit cf, input logic [11:0] match, input bit rdy);
    Digit_valid = dv;
    Digit_in    = dig[2:0];
    Backspace   = bs;
    Clear       = clr;
    Confirm     = cf;
    Match_in    = match;
    Item_ready  = rdy;
    model_step(dv, dig, bs, clr, cf, match, rdy);
    @(negedge clk);
    Digit_valid = 1'b0;
    Backspace   = 1'b0;
    Clear       = 1'b0;
    Confirm     = 1'b0;
    Item_ready  = 1'b0;
    check_all();
  endtask

  task automatic digit(input int d);
    cycle(1'b1, d, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
  endtask

  task automatic idle();
    cycle(1'b0, 0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
  endtask

  task automatic confirm(input logic [11:0] m, input bit rdy);
    cycle(1'b0, 0, 1'b0, 1'b0, 1'b1, m, rdy);
  endtask

  initial begin
    int vcount;
    int r;
    bit dv, bs, clr, cf, rdy;
    int dig;
    logic [11:0] match;

    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    check("rst_barcode", 32'(Barcode_out), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check_all();

    // 3,1,2,4 completes the barcode.
    digit(3); digit(1); digit(2); digit(4);
    check("seq_3124", 32'(Barcode_out), 32'h3124);
    check("seq_cnt4", 32'(NumOfBarcodeDigitsEntered), 32'd4);
    check("seq_done", 32'(BarcodeCompleted), 32'd1);

    // Backspace out of REVIEW, then re-enter.
    cycle(1'b0, 0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0);
    check("bs_3120", 32'(Barcode_out), 32'h3120);
    check("bs_done0", 32'(BarcodeCompleted), 32'd0);
    digit(1);
    check("re_3121", 32'(Barcode_out), 32'h3121);
    check("re_done", 32'(BarcodeCompleted), 32'd1);

    // Lookup hit with the cart stalling for three cycles.
    vcount = 0;
    confirm(12'h001, 1'b0);
    if (Item_valid) vcount++;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
      check("stall_idx", 32'(Item_index), 32'd0);
      if (Item_valid) vcount++;
    end
    cycle(1'b0, 0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1);
    check("valid_cycles", 32'(vcount), 32'd4);
    check("hs_cleared", 32'(NumOfBarcodeDigitsEntered), 32'd0);

    // Lookup misses: empty and multi-hot match.
    digit(4); digit(4); digit(1); digit(2);
    confirm(12'h000, 1'b0);
    check("err_zero", 32'(Error), 32'd1);
    idle();
    check("err_pulse", 32'(Error), 32'd0);
    digit(2); digit(3); digit(1); digit(1);
    confirm(12'h003, 1'b0);
    check("err_multi", 32'(Error), 32'd1);
    check("err_cnt0", 32'(NumOfBarcodeDigitsEntered), 32'd0);

    // Clear beats a simultaneous digit; illegal digit is ignored.
    cycle(1'b1, 2, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0);
    check("clr_dv", 32'(NumOfBarcodeDigitsEntered), 32'd0);
    digit(5);
    check("dig5", 32'(NumOfBarcodeDigitsEntered), 32'd0);

    // Reset in ISSUE drops Item_valid asynchronously.
    digit(1); digit(1); digit(1); digit(1);
    confirm(12'h800, 1'b0);
    check("issue_idx11", 32'(Item_index), 32'd11);
    #1 rst_n = 1'b0;
    #1 check("rst_async_valid", 32'(Item_valid), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    check_all();

`ifdef BARCODE_TIMEOUT_EN
    digit(2);
    for (int i = 0; i < TMO - 1; i++) idle();
    check("tmo_before", 32'(NumOfBarcodeDigitsEntered), 32'd1);
    idle();
    check("tmo_after", 32'(NumOfBarcodeDigitsEntered), 32'd0);
`endif

    for (int n = 0; n < 4000; n++) begin
      dv = 0; bs = 0; clr = 0; cf = 0;
      r = $urandom_range(0, 99);
      if (r < 35) dv = 1;
      else if (r < 45) bs = 1;
      else if (r < 50) clr = 1;
      else if (r < 75) cf = 1;
      if ($urandom_range(0, 19) == 0) begin
        clr = 1; dv = $urandom_range(0, 1); bs = $urandom_range(0, 1); cf = $urandom_range(0, 1);
      end
      dig = ($urandom_range(0, 99) < 85) ? $urandom_range(1, 4) : (($urandom_range(0, 3) == 0) ? 0 : $urandom_range(5, 7));
      r = $urandom_range(0, 9);
      if (r < 6) match = 12'h001 << $urandom_range(0, 11);
      else if (r < 8) match = 12'h000;
      else match = 12'($urandom);
      rdy = ($urandom_range(0, 2) == 0);
      cycle(dv, dig, bs, clr, cf, match, rdy);
      if (m_issue && $urandom_range(0, 19) == 0) begin
        #1 rst_n = 1'b0;
        #1 check("rnd_rst_valid", 32'(Item_valid), 32'd0);
        check("rnd_rst_cnt", 32'(NumOfBarcodeDigitsEntered), 32'd0);
        model_reset();
        #1 rst_n = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
